// File: rtl/fir_adv_pkg.sv
// Shared defaults and state encoding for the 3-parallel FIR front-end controller.
package fir_adv_pkg;

  localparam int FIR_NBIT      = 14;
  localparam int FIR_NTAP      = 11;
  localparam int FIR_DRAIN_CYC = 4;
  localparam int CW_AW         = 4;

  typedef enum logic [1:0] {
    RUN,
    ALIGN,
    DRAIN,
    SWAP
  } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient register file: host writes the shadow copy,
// a single swap strobe copies every shadow tap into the active copy at once.
module fir_coef_bank
  import fir_adv_pkg::*;
#(
  parameter int NBIT = FIR_NBIT,
  parameter int NTAP = FIR_NTAP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CW_AW-1:0]     wr_addr,
  input  logic [NBIT-1:0]      wr_data,
  input  logic                 swap,
  output logic [NTAP*NBIT-1:0] bout
);

  logic [NBIT-1:0] shadow [NTAP];
  logic [NBIT-1:0] active [NTAP];
  logic            wr_hit;

  assign wr_hit = wr_en && (int'({1'b0, wr_addr}) < NTAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) shadow[i] <= '0;
    end else if (wr_hit) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  // A write landing on the swap edge is not seen by the copy; it stays in shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTAP; i++) active[i] <= '0;
    end else if (swap) begin
      for (int i = 0; i < NTAP; i++) active[i] <= shadow[i];
    end
  end

  always_comb begin
    bout = '0;
    for (int i = 0; i < NTAP; i++) bout[i*NBIT +: NBIT] = active[i];
  end

endmodule

// File: rtl/fir_adv_ctrl.sv
// Serial-to-triplet packer plus commit FSM that drains the FIR before
// swapping coefficients, so no output ever mixes old and new taps.
module fir_adv_ctrl
  import fir_adv_pkg::*;
#(
  parameter int NBIT      = FIR_NBIT,
  parameter int NTAP      = FIR_NTAP,
  parameter int DRAIN_CYC = FIR_DRAIN_CYC
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic signed [NBIT-1:0] DIN,
  input  logic                   VIN,
  output logic                   RDY,
  input  logic                   CW_EN,
  input  logic [CW_AW-1:0]       CW_ADDR,
  input  logic [NBIT-1:0]        CW_DATA,
  input  logic                   CW_COMMIT,
  output logic signed [NBIT-1:0] DOUT3k,
  output logic signed [NBIT-1:0] DOUT3k1,
  output logic signed [NBIT-1:0] DOUT3k2,
  output logic                   VOUT,
  output logic [NTAP*NBIT-1:0]   BOUT,
  output logic                   BUSY
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  state_t                 state, state_nxt;
  logic [1:0]             phase, phase_nxt;
  logic signed [NBIT-1:0] slot0, slot1;
  logic                   accept, last_acc;
  logic                   pend, commit_req, swap;
  logic [CNT_W-1:0]       drain_cnt;

  assign accept     = VIN && RDY;
  assign last_acc   = accept && (phase == 2'd2);
  assign phase_nxt  = accept ? ((phase == 2'd2) ? 2'd0 : phase + 2'd1) : phase;
  assign commit_req = CW_COMMIT || pend;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      phase   <= '0;
      slot0   <= '0;
      slot1   <= '0;
      DOUT3k  <= '0;
      DOUT3k1 <= '0;
      DOUT3k2 <= '0;
      VOUT    <= 1'b0;
    end else begin
      VOUT  <= last_acc;
      phase <= phase_nxt;
      if (accept && phase == 2'd0) slot0 <= DIN;
      if (accept && phase == 2'd1) slot1 <= DIN;
      if (last_acc) begin
        DOUT3k  <= slot0;
        DOUT3k1 <= slot1;
        DOUT3k2 <= DIN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // The drain count starts on entry, so a triplet emitted on that edge is drain cycle 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drain_cnt <= '0;
      pend      <= 1'b0;
    end else begin
      if (state_nxt == DRAIN && state != DRAIN)
        drain_cnt <= CNT_W'(DRAIN_CYC - 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;

      if (CW_COMMIT && state != RUN) pend <= 1'b1;
      else if (state == RUN)         pend <= 1'b0;
    end
  end

  // Alignment is judged on the phase after this cycle's accept, so a
  // commit arriving alongside a sample never leaves a partial triplet.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (commit_req) state_nxt = (phase_nxt != 2'd0) ? ALIGN : DRAIN;
      ALIGN:   if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = SWAP;
      SWAP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    RDY  = 1'b0;
    BUSY = 1'b1;
    swap = 1'b0;
    case (state)
      RUN: begin
        RDY  = 1'b1;
        BUSY = pend;
      end
      ALIGN:   RDY  = 1'b1;
      DRAIN:   RDY  = 1'b0;
      SWAP:    swap = 1'b1;
      default: BUSY = 1'b1;
    endcase
  end

  fir_coef_bank #(
    .NBIT(NBIT),
    .NTAP(NTAP)
  ) u_bank (
    .clk    (CLK),
    .rst    (RST),
    .wr_en  (CW_EN),
    .wr_addr(CW_ADDR),
    .wr_data(CW_DATA),
    .swap   (swap),
    .bout   (BOUT)
  );

endmodule

// File: doc/fir_adv_ctrl.md
Name: fir_adv_ctrl

Overview:
Front-end controller for the 3-parallel 11-tap FIR (FIR_adv).
- Packs a serial 1-sample/cycle input stream into aligned triplets (3k, 3k+1, 3k+2) with a single-cycle valid.
- Owns the coefficient bank: a host writes a shadow copy at any time; on commit, the block stalls input, drains the FIR pipeline, and swaps shadow to active atomically, so no output mixes old and new coefficients.

Parameters:
NBIT, 14, sample and coefficient width
NTAP, 11, number of coefficients (B0..B10)
DRAIN_CYC, 4, FIR input-to-output latency in cycles that must elapse with no new triplet before a swap

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
DIN  in  NBIT  serial input sample, signed
VIN  in  1  DIN valid
RDY  out  1  ready for DIN; a sample is accepted when VIN&&RDY
CW_EN  in  1  shadow coefficient write strobe
CW_ADDR  in  4  shadow coefficient index 0..NTAP-1
CW_DATA  in  NBIT  shadow coefficient value
CW_COMMIT  in  1  single-cycle request to swap shadow into active
DOUT3k  out  NBIT  triplet sample 3k (oldest)
DOUT3k1  out  NBIT  triplet sample 3k+1
DOUT3k2  out  NBIT  triplet sample 3k+2 (newest)
VOUT  out  1  triplet valid, one-cycle pulse, drives FIR VIN
BOUT  out  NTAP*NBIT  active coefficients; B0 in bits [NBIT-1:0], Bi in bits [(i+1)*NBIT-1:i*NBIT]
BUSY  out  1  high while a commit is pending, draining or swapping

Behaviour:
- Reset (async, RST=1): state RUN, phase=0, slots=0, shadow=0, active=0, DOUT*=0, VOUT=0, BUSY=0, pend=0. RDY is combinational and equals 1 in RUN and ALIGN.
- Packer: 2-bit phase counter, values 0..2.
  - On accept: slot[phase]<=DIN, phase advances and wraps 2->0.
  - Accept at phase 2: next cycle DOUT3k=slot0, DOUT3k1=slot1, DOUT3k2=that DIN, VOUT=1. Latency is 1 cycle from the third sample.
  - Otherwise VOUT=0. DOUT* hold their last value when VOUT=0.
  - No accept: phase and slots hold; gaps in VIN are allowed.
- Shadow writes: CW_EN with CW_ADDR<NTAP writes shadow[CW_ADDR] in any state. CW_ADDR>=NTAP is ignored.
- FSM states: RUN, ALIGN, DRAIN, SWAP.
  - RUN: CW_COMMIT goes to ALIGN if phase!=0, else to DRAIN.
  - ALIGN: keep accepting. Move to DRAIN on the cycle the phase-2 accept occurs (that triplet is emitted). This guarantees no partial triplet straddles the swap.
  - DRAIN: RDY=0. The counter loads DRAIN_CYC-1 on entry and counts down. Go to SWAP at 0. A triplet emitted on the DRAIN entry cycle counts as cycle 0 of the drain.
  - SWAP: one cycle, RDY=0. Active<=shadow, copying all taps in the same edge. Then RUN.
- BUSY=1 in ALIGN, DRAIN and SWAP.
- CW_COMMIT outside RUN sets a pend flag. Pend is consumed on return to RUN, triggering a further commit. Multiple commits while pending collapse to one.
- CW_EN in the SWAP cycle: the copy uses the pre-write shadow value. The write lands in shadow only and needs another commit.
- BOUT changes only on the SWAP edge and is stable otherwise.
- Arithmetic: none on the data path; samples pass bit-exact. Counters saturate-free by construction.

Decomposition:
- Package fir_adv_pkg: NBIT, NTAP, DRAIN_CYC defaults, and the FSM state enum {RUN, ALIGN, DRAIN, SWAP}.
- One sub-module: fir_coef_bank (shadow+active register file with write port and swap strobe, flat BOUT output).
- The packer and FSM stay in the top.

Test Plan:
- Reset mid-stream: assert RST after 2 accepted samples -> all outputs 0, RDY=1, BUSY=0, BOUT=0 immediately (asynchronous). The next 3 samples form a fresh triplet.
- Packing: DIN=1,2,3,4,5,6 on consecutive cycles, VIN=1 -> VOUT pulses on cycles 4 and 7 with (1,2,3) and (4,5,6). Repeat with VIN gaps; the same triplets must result.
- Aligned commit: write shadow[i]=i+1 for i=0..10, commit at phase 0 -> RDY low for DRAIN_CYC+1=5 cycles. BOUT becomes 1..11 on the SWAP edge, BUSY high exactly 5 cycles, no VOUT during drain.
- Unaligned commit: commit at phase 1 -> ALIGN accepts 2 more samples, the triplet is emitted, then the drain and swap follow. BOUT must not change before that triplet's VOUT.
- Commit during DRAIN plus CW_EN addr 3 value 0x1FFF in the SWAP cycle -> first swap leaves active[3] old. A second ALIGN/DRAIN/SWAP runs automatically and active[3]=0x1FFF afterwards.
- Illegal address: CW_EN with addr 11..15 -> shadow is unchanged, verified after a commit.
